// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and defaults for the integrate-and-fire neuron scheduler
package snn_pkg;

    typedef enum logic {
        ST_SERVE = 1'b0,
        ST_LEAK  = 1'b1
    } state_e;

    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_POT_W     = 4;
    localparam int DEF_THRESHOLD = 2;

    typedef logic [DEF_ADDR_W-1:0] neuron_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, first request at or after the pointer wins
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [PTR_W-1:0] idx;

    // Scan from the pointer with wrap; the first hit is the only grant.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (en && !grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_neuron_scheduler.sv
// rtl/if_neuron_scheduler.sv - time-multiplexed integrate-and-fire neuron bank with leak sweep
module if_neuron_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int POT_W       = DEF_POT_W,
    parameter int THRESHOLD   = DEF_THRESHOLD
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tick,
    output logic                      fire_valid,
    output logic [ADDR_W-1:0]         fire_addr,
    input  logic                      fire_ready,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state;
    state_e             state_nxt;
    logic [ADDR_W-1:0]  leak_idx;
    logic               leak_pending;
    logic               leak_last;
    logic               leak_again;
    logic [PTR_W-1:0]   rr_ptr;
    logic [POT_W-1:0]   pot [NUM_NEURONS];

    logic               out_free;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [ADDR_W-1:0]  grant_addr;
    logic [POT_W-1:0]   grant_pot;
    logic               grant_fires;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    // A held fire event stalls all grants; leak (pending or arriving now) wins over spikes.
    assign out_free    = !fire_valid || fire_ready;
    assign arb_en      = reset_n && (state == ST_SERVE) && !leak_pending && !tick && out_free;
    assign leak_last   = (leak_idx == ADDR_W'(NUM_NEURONS - 1));
    assign leak_again  = leak_pending || tick;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign req_ready   = grant;
    assign grant_addr  = addr_arr[grant_idx];
    assign grant_pot   = pot[grant_addr];
    assign grant_fires = (grant_pot >= POT_W'(THRESHOLD));
    assign busy        = (state == ST_LEAK) || leak_pending;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_SERVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a sweep chains straight into another if a tick arrived during it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SERVE: if (leak_again) state_nxt = ST_LEAK;
            ST_LEAK:  if (leak_last && !leak_again) state_nxt = ST_SERVE;
            default:  state_nxt = ST_SERVE;
        endcase
    end

    // Sweep index and the one-deep pending-tick flag (cleared whenever a sweep starts).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leak_idx     <= '0;
            leak_pending <= 1'b0;
        end else if (state == ST_LEAK) begin
            leak_idx <= leak_idx + ADDR_W'(1);
            if (leak_last) begin
                leak_pending <= 1'b0;
            end else if (tick) begin
                leak_pending <= 1'b1;
            end
        end else begin
            leak_idx     <= '0;
            leak_pending <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Single write port: leak halves one neuron, or a grant integrates/resets one neuron.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot[i] <= '0;
            end
        end else if (state == ST_LEAK) begin
            pot[leak_idx] <= pot[leak_idx] >> 1;
        end else if (grant_vld) begin
            pot[grant_addr] <= grant_fires ? '0 : grant_pot + POT_W'(1);
        end
    end

    // One-entry fire output; a new fire wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire_valid <= 1'b0;
            fire_addr  <= '0;
        end else if (grant_vld && grant_fires) begin
            fire_valid <= 1'b1;
            fire_addr  <= grant_addr;
        end else if (fire_ready) begin
            fire_valid <= 1'b0;
        end
    end

endmodule

// File: doc/if_neuron_scheduler.md
Name: if_neuron_scheduler

Overview:
Time-multiplexed controller for a bank of integrate-and-fire neurons. Membrane potentials live in one internal register array, and a single shared update datapath serves all of them. The block arbitrates spike events from several requesters round-robin, performs one read-modify-write per cycle, and runs a leak sweep (halve every potential) on each timestep tick. Fire events leave through a valid/ready output toward downstream routing.

Parameters:
NUM_REQ, 4, number of spike requester channels
NUM_NEURONS, 16, number of virtual neurons; power of two
ADDR_W, 4, log2(NUM_NEURONS); neuron address width
POT_W, 4, membrane potential width, unsigned
THRESHOLD, 2, fire when pre-increment potential >= THRESHOLD; must be < 2**POT_W - 1

Ports:
clk  input  1  single clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester spike valid
req_addr  input  NUM_REQ*ADDR_W  per-requester target neuron; requester i at bits [i*ADDR_W +: ADDR_W]
req_ready  output  NUM_REQ  one-hot grant; at most one bit high per cycle
tick  input  1  timestep pulse; requests a leak sweep
fire_valid  output  1  fire event pending
fire_addr  output  ADDR_W  neuron that fired
fire_ready  input  1  downstream accepts fire event
busy  output  1  high in LEAK or while a sweep is pending

Behaviour:
- Reset (async assert, sync release): all potentials 0; state IDLE; rr pointer 0; leak_pending 0; fire_valid 0; fire_addr 0; req_ready 0; busy 0.
- States: IDLE/INTEGRATE (one merged serving state) and LEAK.
- Serving state:
  - If leak_pending or tick is high, transition to LEAK next cycle. No grant is issued in that cycle; leak has priority over requests arriving in the same cycle.
  - Otherwise, with out_free = !fire_valid || fire_ready, grant the first req_valid at or after rr pointer (wrapping) when out_free is high.
  - On a grant, the rr pointer moves to granted index + 1, mod NUM_REQ.
  - req_ready is combinational from req_valid, state and out_free. A requester never sees ready without its own valid.
- Update for granted address a, p = pot[a]:
  - If p >= THRESHOLD: pot[a] <= 0; fire_valid <= 1; fire_addr <= a at the same edge.
  - Otherwise: pot[a] <= p + 1.
- Latency:
  - A grant in cycle N gives fire_valid in cycle N+1.
  - A back-to-back grant to the same neuron in N+1 sees the updated value.
- Output register is one entry. fire_valid clears on the fire_ready handshake unless a new fire loads in the same cycle. A held fire_valid with fire_ready low blocks all grants.
- LEAK:
  - Sweep index k runs 0..NUM_NEURONS-1, one neuron per cycle: pot[k] <= pot[k] >> 1.
  - After k = NUM_NEURONS-1, return to serving; leak_pending clears at sweep entry.
  - No grants during LEAK. The output register still drains.
  - A tick during LEAK sets leak_pending, which causes exactly one further sweep immediately after. Multiple ticks during one sweep collapse into one.
- busy = (state == LEAK) || leak_pending.
- Potential arithmetic is unsigned POT_W. Increment cannot overflow because THRESHOLD < max.
- A reset mid-sweep or mid-stall aborts everything to reset values. A pending fire event is lost.

Decomposition:
- Shared package snn_pkg holds the state enum (ST_SERVE, ST_LEAK), default POT_W/THRESHOLD constants and the neuron address typedef.
- Sub-module rr_arbiter (NUM_REQ, parametric) takes req, pointer and enable, and produces a one-hot grant plus the encoded index.
- The potential array and update datapath stay in the top.

Test Plan:
- Three spikes to neuron 3 from requester 0 on consecutive cycles -> pot[3] goes 1, 2, then fire_valid=1 with fire_addr=3 in the cycle after the third grant; pot[3]=0.
- All four requesters valid continuously, each targeting a distinct neuron -> grants rotate 0,1,2,3,0... Each neuron fires on its 3rd grant.
- Fire pending with fire_ready=0 for 5 cycles and requests valid -> req_ready=0 for all 5 cycles. Grants resume in the cycle fire_ready=1.
- pot[5]=2, pot[9]=1, then tick in the same cycle as a req_valid -> no grant. LEAK runs 16 cycles; afterwards pot[5]=1, pot[9]=0; the request is granted after the sweep.
- Two ticks during one sweep -> exactly two sweeps total (32 LEAK cycles). busy stays high throughout and drops the cycle after the second sweep ends.
- reset_n asserted mid-sweep with a fire pending -> fire_valid=0, busy=0 and all pot=0 immediately; first grant after release comes from requester 0.
